ab_stim_gen: RTL and testbench
==============================

AB_STIM_GEN -- requirements
Module: ab_stim_gen

Interface
REQ-001 Parameter DEPTH, default 8: maximum number of pattern entries in one sequence.
REQ-002 Parameter HOLD_W, default 4: width of the per-entry hold count.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begins a sequence when sampled high in IDLE.
REQ-006 stop  input  1  aborts a running sequence.
REQ-007 repeat_en  input  1  when high at start, the sequence loops until stop.
REQ-008 seq_data  input  2*DEPTH  pattern table; entry i = seq_data[2i+1:2i], bit1 = a, bit0 = b.
REQ-009 seq_len  input  $clog2(DEPTH)+1  number of entries; 0 means DEPTH; values above DEPTH are clamped to DEPTH.
REQ-010 hold  input  HOLD_W  each entry is driven for hold+1 cycles.
REQ-011 a, b  output  1 each  driven stimulus bits, registered.
REQ-012 exp_and, exp_or, exp_xor  output  1 each  registered a&&b, a||b, a^b, cycle-aligned with a/b.
REQ-013 sample  output  1  pulses high on the last cycle of each entry's hold; the checker samples there.
REQ-014 busy  output  1  high while in DRIVE.
REQ-015 done  output  1  one-cycle pulse after a non-repeating sequence completes.

Function
REQ-016 FSM states: IDLE, DRIVE, DONE.
REQ-017 IDLE -> DRIVE on start=1 and stop=0; on that edge, seq_data, seq_len (normalised), hold and repeat_en are latched. Later input changes do not affect the running sequence.
REQ-018 Latency: with start high at edge T, a/b = entry 0 and busy=1 from T+1.
REQ-019 Each entry holds a/b stable for exactly hold+1 cycles. sample=1 only on the final cycle of that hold.
REQ-020 The entry index increments after the final hold cycle. On the last entry with repeat off, the FSM goes DRIVE -> DONE.
REQ-021 DONE lasts one cycle: done=1, busy=0, a=b=0. The FSM then returns to IDLE.
REQ-022 With repeat on, the index wraps from len-1 to 0 with no gap cycle. done never pulses.
REQ-023 stop=1 in DRIVE: on the next cycle a=b=0, busy=0, FSM=IDLE, and done stays 0. stop has priority over sequence completion in the same cycle.
REQ-024 start is ignored while busy or in DONE. In IDLE, stop=1 with start=1 gives no start.
REQ-025 In IDLE, a=b=0, the exp_* outputs follow a=b=0 (and=0, or=0, xor=0), and sample=0.
REQ-026 hold=0: every cycle of DRIVE is a sample cycle, and entries change every cycle.
REQ-027 The hold counter is HOLD_W bits, counts down from the latched hold to 0, and never wraps.

Reset
REQ-028 While rst is asserted: FSM=IDLE, entry index=0, hold counter=0, and all outputs=0. Reset takes effect asynchronously.
REQ-029 rst asserted mid-sequence aborts immediately, with no done pulse. After deassertion, a new start is required.

Structure
REQ-030 Package ab_stim_pkg holds the state enum (IDLE, DRIVE, DONE) and the default DEPTH/HOLD_W constants.
REQ-031 Sub-module ab_hold_timer: loadable down-counter with a terminal-count output, which drives sample and the entry advance.
REQ-032 All outputs come directly from flops, with no combinational input-to-output paths.

Verification
REQ-033 seq_data=16'h001B, seq_len=4, hold=1, start at T -> a/b = 11,11,10,10,01,01,00,00 from T+1; sample high on cycles T+2, T+4, T+6, T+8; done at T+9; exp_xor=0,0,1,1,1,1,0,0.
REQ-034 Same table with repeat_en=1 -> after 00, entry 11 follows on the next cycle; no done; stop at T+12 gives a=b=0 and busy=0 at T+13.
REQ-035 seq_len=0, hold=0, seq_data=16'hAAAA -> 8 consecutive cycles of a=1, b=0 with sample every cycle; done on the 9th cycle.
REQ-036 start pulsed again while busy, and seq_data changed mid-run -> output sequence unchanged; exactly one done.
REQ-037 rst asserted asynchronously between clock edges mid-DRIVE -> all outputs 0 before the next edge; no done; a fresh start runs normally.
REQ-038 start and stop both high in IDLE -> busy stays 0; stop coinciding with the final sample cycle -> no done.

Source files
------------

// File: rtl/ab_stim_pkg.sv
// rtl/ab_stim_pkg.sv - shared state encoding and default sizing for the a/b stimulus generator
package ab_stim_pkg;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/ab_stim_gen_if.sv
// rtl/ab_stim_gen_if.sv - control inputs and stimulus/expected outputs of the a/b stimulus generator
interface ab_stim_gen_if
  import ab_stim_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic               start;
  logic               stop;
  logic               repeat_en;
  logic [2*DEPTH-1:0] seq_data;
  logic [LW-1:0]      seq_len;
  logic [HOLD_W-1:0]  hold;
  logic               a;
  logic               b;
  logic               exp_and;
  logic               exp_or;
  logic               exp_xor;
  logic               sample;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, repeat_en, seq_data, seq_len, hold,
    input  a, b, exp_and, exp_or, exp_xor, sample, busy, done
  );

  modport slave (
    input  start, stop, repeat_en, seq_data, seq_len, hold,
    output a, b, exp_and, exp_or, exp_xor, sample, busy, done
  );
endinterface

// File: rtl/ab_hold_timer.sv
// rtl/ab_hold_timer.sv - loadable saturating down-counter with terminal count and next-cycle terminal count
module ab_hold_timer
  import ab_stim_pkg::*;
#(
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [HOLD_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_tc,
  output logic              o_tc_next
);
  logic [HOLD_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - HOLD_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

  // Lets the owner register a flag that is high exactly while the count sits at zero.
  always_comb begin
    if (i_load) begin
      o_tc_next = (i_load_val == '0);
    end else if (i_en) begin
      o_tc_next = (r_count <= HOLD_W'(1));
    end else begin
      o_tc_next = (r_count == '0);
    end
  end
endmodule

// File: rtl/ab_stim_gen.sv
// rtl/ab_stim_gen.sv - table-driven a/b stimulus generator with registered expected AND/OR/XOR
module ab_stim_gen
  import ab_stim_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input logic         clk,
  input logic         rst,
  ab_stim_gen_if.slave s
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [LW-1:0]           r_len;
  logic [DEPTH-1:0][1:0]   r_data;
  logic [HOLD_W-1:0]       r_hold;
  logic                    r_rep;
  logic                    r_a, r_b, r_and, r_or, r_xor, r_sample, r_busy, r_done;

  state_t                  w_nxt_state;
  logic [IW-1:0]           w_nxt_idx;
  logic [1:0]              w_nxt_ab;
  logic                    w_nxt_busy, w_nxt_done, w_nxt_sample;
  logic                    w_latch;
  logic                    w_t_load, w_t_en, w_tc, w_tc_next;
  logic [HOLD_W-1:0]       w_t_load_val;
  logic [LW-1:0]           w_len_norm;
  logic                    w_last;

  assign w_len_norm = ((s.seq_len == '0) || (s.seq_len > LW'(DEPTH))) ? LW'(DEPTH) : s.seq_len;
  assign w_last     = (LW'(r_idx) == (r_len - LW'(1)));

  ab_hold_timer #(.HOLD_W(HOLD_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_t_load),
    .i_load_val (w_t_load_val),
    .i_en       (w_t_en),
    .o_tc       (w_tc),
    .o_tc_next  (w_tc_next)
  );

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_idx    = r_idx;
    w_nxt_ab     = 2'b00;
    w_nxt_busy   = 1'b0;
    w_nxt_done   = 1'b0;
    w_nxt_sample = 1'b0;
    w_latch      = 1'b0;
    w_t_load     = 1'b0;
    w_t_load_val = '0;
    w_t_en       = 1'b0;
    case (r_state)
      IDLE: begin
        if (s.start && !s.stop) begin
          w_latch      = 1'b1;
          w_nxt_state  = DRIVE;
          w_nxt_idx    = '0;
          w_nxt_ab     = s.seq_data[1:0];
          w_nxt_busy   = 1'b1;
          w_t_load     = 1'b1;
          w_t_load_val = s.hold;
          w_nxt_sample = w_tc_next;
        end
      end
      DRIVE: begin
        // stop wins over completion; the timer is cleared on every exit from DRIVE.
        if (s.stop) begin
          w_nxt_state = IDLE;
          w_nxt_idx   = '0;
          w_t_load    = 1'b1;
        end else if (w_tc && w_last && !r_rep) begin
          w_nxt_state = DONE;
          w_nxt_idx   = '0;
          w_nxt_done  = 1'b1;
          w_t_load    = 1'b1;
        end else if (w_tc) begin
          w_nxt_idx    = w_last ? '0 : (r_idx + IW'(1));
          w_nxt_ab     = r_data[w_nxt_idx];
          w_nxt_busy   = 1'b1;
          w_t_load     = 1'b1;
          w_t_load_val = r_hold;
          w_nxt_sample = w_tc_next;
        end else begin
          w_nxt_ab     = r_data[r_idx];
          w_nxt_busy   = 1'b1;
          w_t_en       = 1'b1;
          w_nxt_sample = w_tc_next;
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_len    <= '0;
      r_data   <= '0;
      r_hold   <= '0;
      r_rep    <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_and    <= 1'b0;
      r_or     <= 1'b0;
      r_xor    <= 1'b0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_len  <= w_len_norm;
        r_data <= s.seq_data;
        r_hold <= s.hold;
        r_rep  <= s.repeat_en;
      end
      r_idx    <= w_nxt_idx;
      r_a      <= w_nxt_ab[1];
      r_b      <= w_nxt_ab[0];
      r_and    <= w_nxt_ab[1] & w_nxt_ab[0];
      r_or     <= w_nxt_ab[1] | w_nxt_ab[0];
      r_xor    <= w_nxt_ab[1] ^ w_nxt_ab[0];
      r_sample <= w_nxt_sample;
      r_busy   <= w_nxt_busy;
      r_done   <= w_nxt_done;
    end
  end

  assign s.a       = r_a;
  assign s.b       = r_b;
  assign s.exp_and = r_and;
  assign s.exp_or  = r_or;
  assign s.exp_xor = r_xor;
  assign s.sample  = r_sample;
  assign s.busy    = r_busy;
  assign s.done    = r_done;
endmodule

// File: tb/tb_ab_stim_gen.sv
// tb/tb_ab_stim_gen.sv - scoreboard bench for ab_stim_gen
module tb_ab_stim_gen;
  import ab_stim_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ab_stim_gen_if #(.DEPTH(8), .HOLD_W(4)) s ();

  ab_stim_gen #(.DEPTH(8), .HOLD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s)
  );

  // {a, b, and, or, xor, sample, busy, done}
  function automatic logic [7:0] vec(input logic a, input logic b, input logic smp,
                                     input logic bsy, input logic dn);
    return {a, b, a & b, a | b, a ^ b, smp, bsy, dn};
  endfunction

  function automatic logic [7:0] obs();
    return {s.a, s.b, s.exp_and, s.exp_or, s.exp_xor, s.sample, s.busy, s.done};
  endfunction

  task automatic push_seq(input logic [15:0] data, input int len, input int hold, input int ncyc);
    int l;
    int i;
    int c;
    l = ((len == 0) || (len > 8)) ? 8 : len;
    i = 0;
    c = 0;
    while (c < ncyc) begin
      for (int h = 0; h <= hold && c < ncyc; h++) begin
        exp_q.push_back(vec(data[2*i+1], data[2*i], h == hold, 1'b1, 1'b0));
        c++;
      end
      i = (i + 1) % l;
    end
  endtask

  task automatic push_done_idle(input int n_idle);
    exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < n_idle; k++) exp_q.push_back(8'h00);
  endtask

  task automatic launch(input logic [15:0] data, input logic [3:0] len, input logic [3:0] hold,
                        input logic rep);
    s.seq_data  = data;
    s.seq_len   = len;
    s.hold      = hold;
    s.repeat_en = rep;
    s.start     = 1'b1;
    @(posedge clk);
    #1;
    s.start     = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    #12;
    got = obs();
    n_run++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", got, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got = obs();
    n_run++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_released: got %b want %b", got, 8'h00);
    end
  endtask

  task automatic test_basic();
    logic [7:0] got, want;
    push_seq(16'h001B, 4, 1, 8);
    push_done_idle(1);
    launch(16'h001B, 4'd4, 4'd1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic cyc %0d: got %b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_repeat();
    logic [7:0] got, want;
    push_seq(16'h001B, 4, 1, 12);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    launch(16'h001B, 4'd4, 4'd1, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL repeat cyc %0d: got %b want %b", k, got, want);
      end
      if (k == 12) s.stop = 1'b1;
      if (k == 13) s.stop = 1'b0;
      @(posedge clk);
      #1;
    end
    s.repeat_en = 1'b0;
  endtask

  task automatic test_len0_hold0();
    logic [7:0] got, want;
    push_seq(16'hAAAA, 0, 0, 8);
    push_done_idle(1);
    launch(16'hAAAA, 4'd0, 4'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL len0_hold0 cyc %0d: got %b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_len_clamp();
    logic [7:0] got, want;
    push_seq(16'h9C36, 15, 0, 8);
    push_done_idle(0);
    launch(16'h9C36, 4'd15, 4'd0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL len_clamp cyc %0d: got %b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_hold2();
    logic [7:0] got, want;
    push_seq(16'h0006, 2, 2, 6);
    push_done_idle(1);
    launch(16'h0006, 4'd2, 4'd2, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL hold2 cyc %0d: got %b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_restart();
    logic [7:0] got, want;
    int done_cnt;
    done_cnt = 0;
    push_seq(16'h001B, 4, 1, 8);
    push_done_idle(2);
    launch(16'h001B, 4'd4, 4'd1, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL no_restart cyc %0d: got %b want %b", k, got, want);
      end
      done_cnt += int'(s.done);
      if (k == 2)  s.seq_data = 16'hFFFF;
      if (k == 3)  s.start = 1'b1;
      if (k == 4)  s.start = 1'b0;
      if (k == 9)  s.start = 1'b1;
      if (k == 10) s.start = 1'b0;
      @(posedge clk);
      #1;
    end
    n_run++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL no_restart_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got, want;
    push_seq(16'h001B, 4, 1, 3);
    launch(16'h001B, 4'd4, 4'd1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_pre cyc %0d: got %b want %b", k, got, want);
      end
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    got = obs();
    n_run++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst_immediate: got %b want %b", got, 8'h00);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      got = obs();
      n_run++;
      if (got !== 8'h00) begin
        n_fail++;
        $display("FAIL async_rst_after cyc %0d: got %b want %b", k, got, 8'h00);
      end
    end
    push_seq(16'h001B, 4, 1, 8);
    push_done_idle(1);
    launch(16'h001B, 4'd4, 4'd1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_fresh cyc %0d: got %b want %b", k, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_stop_idle();
    logic [7:0] got;
    s.start = 1'b1;
    s.stop  = 1'b1;
    @(posedge clk);
    #1;
    s.start = 1'b0;
    s.stop  = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      got = obs();
      n_run++;
      if (got !== 8'h00) begin
        n_fail++;
        $display("FAIL start_stop_idle cyc %0d: got %b want %b", k, got, 8'h00);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stop_final();
    logic [7:0] got, want;
    push_seq(16'h001B, 4, 1, 8);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    launch(16'h001B, 4'd4, 4'd1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      got  = obs();
      want = exp_q.pop_front();
      n_run++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop_final cyc %0d: got %b want %b", k, got, want);
      end
      if (k == 8) s.stop = 1'b1;
      if (k == 9) s.stop = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    s.start     = 1'b0;
    s.stop      = 1'b0;
    s.repeat_en = 1'b0;
    s.seq_data  = '0;
    s.seq_len   = '0;
    s.hold      = '0;
    test_reset();
    test_basic();
    test_repeat();
    test_len0_hold0();
    test_len_clamp();
    test_hold2();
    test_no_restart();
    test_async_reset();
    test_start_stop_idle();
    test_stop_final();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
